// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the ID-stage forwarding/hazard controller.
//  - FWD_* : EX-stage operand mux select encodings
//  - slot_t: shadow-pipeline destination record {valid, rd, regwrite, memread}
//  - is_writer(): slot will write a non-zero register
package cpu_defs;

    localparam int unsigned REG_W = 5;
    localparam int unsigned SEL_W = 2;

    localparam logic [SEL_W-1:0] FWD_REG = 2'b00;  // register file
    localparam logic [SEL_W-1:0] FWD_WB  = 2'b01;  // MEM/WB result
    localparam logic [SEL_W-1:0] FWD_MEM = 2'b10;  // EX/MEM result

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             regwrite;
        logic             memread;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

    // r0 is hard-wired zero, so a write to it never produces a forwardable value
    function automatic logic is_writer(input slot_t s);
        return s.valid & s.regwrite & (s.rd != '0);
    endfunction

endpackage

// File: rtl/fwd_sel_unit.sv
// Per-operand forwarding select.
//  src_i      : source register read by the ID instruction
//  use_i      : ID instruction actually reads src_i
//  ex_slot_i  : destination info of the instruction currently in EX
//  mem_slot_i : destination info of the instruction currently in MEM
//  sel_o      : select for this operand once the ID instruction reaches EX (combinational)
module fwd_sel_unit
    import cpu_defs::*;
(
    input  logic [REG_W-1:0] src_i,
    input  logic             use_i,
    input  slot_t            ex_slot_i,
    input  slot_t            mem_slot_i,
    output logic [SEL_W-1:0] sel_o
);

    // Load-ness is handled by the stall logic in the top level
    logic w_unused_memread;
    assign w_unused_memread = ex_slot_i.memread ^ mem_slot_i.memread;

    // Newest producer wins: the instruction now in EX will sit in MEM next cycle
    always_comb begin
        sel_o = FWD_REG;
        if (use_i) begin
            if (is_writer(ex_slot_i) && (ex_slot_i.rd == src_i)) begin
                sel_o = FWD_MEM;
            end else if (is_writer(mem_slot_i) && (mem_slot_i.rd == src_i)) begin
                sel_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller beside the ID stage of the 5-stage pipeline.
//  clk_i, rst_i (sync, active-low)
//  id_*           : decoded ID-stage instruction fields
//  branch_taken_i : branch resolved taken in ID
//  hold_i         : global freeze
//  fwd_a/b_sel_o  : registered EX operand mux selects (00 regfile, 01 MEM/WB, 10 EX/MEM)
//  stall_o, flush_o, pc_write_o : combinational pipeline controls
//  stall_cnt_o, flush_cnt_o     : saturating event counters
module fwd_hazard_ctrl
    import cpu_defs::*;
#(
    parameter int unsigned REG_W = cpu_defs::REG_W,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_use_rs_i,
    input  logic             id_use_rt_i,
    input  logic [REG_W-1:0] id_rd_i,
    input  logic             id_regwrite_i,
    input  logic             id_memread_i,
    input  logic             branch_taken_i,
    input  logic             hold_i,
    output logic [1:0]       fwd_a_sel_o,
    output logic [1:0]       fwd_b_sel_o,
    output logic             stall_o,
    output logic             flush_o,
    output logic             pc_write_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    slot_t            r_ex;
    slot_t            r_mem;
    slot_t            r_wb;
    logic [SEL_W-1:0] r_fwd_a;
    logic [SEL_W-1:0] r_fwd_b;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    slot_t            w_id_slot;
    logic             w_lu;
    logic             w_stall;
    logic             w_flush;
    logic [SEL_W-1:0] w_sel_a;
    logic [SEL_W-1:0] w_sel_b;

    // WB results reach ID through the write-first register file; the slot is kept for observability
    logic w_unused_wb;
    assign w_unused_wb = ^r_wb;

    always_comb begin
        w_id_slot          = SLOT_EMPTY;
        w_id_slot.valid    = id_valid_i;
        w_id_slot.rd       = id_rd_i;
        w_id_slot.regwrite = id_regwrite_i;
        w_id_slot.memread  = id_memread_i;
    end

    // Load in EX feeding the ID instruction: its data is not ready until after MEM
    assign w_lu = id_valid_i & is_writer(r_ex) & r_ex.memread
                & ((id_use_rs_i & (r_ex.rd == id_rs_i)) | (id_use_rt_i & (r_ex.rd == id_rt_i)));

    assign w_stall = rst_i & w_lu & ~hold_i;
    assign w_flush = rst_i & branch_taken_i & id_valid_i & ~w_lu & ~hold_i;

    assign stall_o    = w_stall;
    assign flush_o    = w_flush;
    assign pc_write_o = ~rst_i | ~(w_lu | hold_i);

    fwd_sel_unit u_sel_a (
        .src_i      (id_rs_i),
        .use_i      (id_use_rs_i),
        .ex_slot_i  (r_ex),
        .mem_slot_i (r_mem),
        .sel_o      (w_sel_a)
    );

    fwd_sel_unit u_sel_b (
        .src_i      (id_rt_i),
        .use_i      (id_use_rt_i),
        .ex_slot_i  (r_ex),
        .mem_slot_i (r_mem),
        .sel_o      (w_sel_b)
    );

    // Shadow pipeline, select registers and event counters; hold freezes everything
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_ex        <= SLOT_EMPTY;
            r_mem       <= SLOT_EMPTY;
            r_wb        <= SLOT_EMPTY;
            r_fwd_a     <= FWD_REG;
            r_fwd_b     <= FWD_REG;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (!hold_i) begin
            r_wb    <= r_mem;
            r_mem   <= r_ex;
            r_ex    <= w_lu ? SLOT_EMPTY : w_id_slot;
            r_fwd_a <= (w_lu | ~id_valid_i) ? FWD_REG : w_sel_a;
            r_fwd_b <= (w_lu | ~id_valid_i) ? FWD_REG : w_sel_b;
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign fwd_a_sel_o = r_fwd_a;
    assign fwd_b_sel_o = r_fwd_b;
    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: instruction sequences with hand-computed selects,
// stall/flush behaviour, hold freeze and mid-stream reset.
module tb_fwd_hazard_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        id_valid_i;
    logic [4:0]  id_rs_i;
    logic [4:0]  id_rt_i;
    logic        id_use_rs_i;
    logic        id_use_rt_i;
    logic [4:0]  id_rd_i;
    logic        id_regwrite_i;
    logic        id_memread_i;
    logic        branch_taken_i;
    logic        hold_i;
    logic [1:0]  fwd_a_sel_o;
    logic [1:0]  fwd_b_sel_o;
    logic        stall_o;
    logic        flush_o;
    logic        pc_write_o;
    logic [15:0] stall_cnt_o;
    logic [15:0] flush_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    fwd_hazard_ctrl #(.REG_W(5), .CNT_W(16)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .id_valid_i     (id_valid_i),
        .id_rs_i        (id_rs_i),
        .id_rt_i        (id_rt_i),
        .id_use_rs_i    (id_use_rs_i),
        .id_use_rt_i    (id_use_rt_i),
        .id_rd_i        (id_rd_i),
        .id_regwrite_i  (id_regwrite_i),
        .id_memread_i   (id_memread_i),
        .branch_taken_i (branch_taken_i),
        .hold_i         (hold_i),
        .fwd_a_sel_o    (fwd_a_sel_o),
        .fwd_b_sel_o    (fwd_b_sel_o),
        .stall_o        (stall_o),
        .flush_o        (flush_o),
        .pc_write_o     (pc_write_o),
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Present one ID-stage instruction and let combinational outputs settle
    task automatic issue(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic br);
        id_valid_i     = v;
        id_rs_i        = rs;
        id_rt_i        = rt;
        id_use_rs_i    = urs;
        id_use_rt_i    = urt;
        id_rd_i        = rd;
        id_regwrite_i  = rw;
        id_memread_i   = mr;
        branch_taken_i = br;
        #1;
    endtask

    initial begin
        rst_i  = 1'b0;
        hold_i = 1'b0;
        issue(1, 1, 2, 1, 1, 0, 0, 0, 1);
        step();
        step();
        check("rst_sel_a", 32'(fwd_a_sel_o), 0);
        check("rst_sel_b", 32'(fwd_b_sel_o), 0);
        check("rst_stall", 32'(stall_o), 0);
        check("rst_flush", 32'(flush_o), 0);
        check("rst_pcw", 32'(pc_write_o), 1);
        check("rst_scnt", 32'(stall_cnt_o), 0);
        check("rst_fcnt", 32'(flush_cnt_o), 0);
        rst_i = 1'b1;
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();

        // add r3,r1,r2 ; sub r4,r3,r5
        issue(1, 1, 2, 1, 1, 3, 1, 0, 0);
        step();
        issue(1, 3, 5, 1, 1, 4, 1, 0, 0);
        check("exfwd_stall", 32'(stall_o), 0);
        step();
        check("exfwd_a", 32'(fwd_a_sel_o), 2);
        check("exfwd_b", 32'(fwd_b_sel_o), 0);

        // producer r3, unrelated, consumer of r3 in rt
        issue(1, 8, 9, 1, 1, 3, 1, 0, 0);
        step();
        issue(1, 11, 12, 1, 1, 10, 1, 0, 0);
        step();
        issue(1, 14, 3, 1, 1, 13, 1, 0, 0);
        check("wbfwd_stall", 32'(stall_o), 0);
        step();
        check("wbfwd_b", 32'(fwd_b_sel_o), 1);
        check("wbfwd_a", 32'(fwd_a_sel_o), 0);

        // lw r2 ; add r4,r2,r2
        issue(1, 1, 0, 1, 0, 2, 1, 1, 0);
        step();
        issue(1, 2, 2, 1, 1, 4, 1, 0, 0);
        check("lu_stall", 32'(stall_o), 1);
        check("lu_pcw", 32'(pc_write_o), 0);
        check("lu_flush", 32'(flush_o), 0);
        step();
        check("lu_bub_a", 32'(fwd_a_sel_o), 0);
        check("lu_bub_b", 32'(fwd_b_sel_o), 0);
        check("lu_scnt", 32'(stall_cnt_o), 1);
        check("lu_stall_off", 32'(stall_o), 0);
        check("lu_pcw_on", 32'(pc_write_o), 1);
        step();
        check("lu_after_a", 32'(fwd_a_sel_o), 1);
        check("lu_after_b", 32'(fwd_b_sel_o), 1);
        check("lu_scnt2", 32'(stall_cnt_o), 1);

        // two writers of r7, newest wins
        issue(1, 1, 1, 1, 1, 7, 1, 0, 0);
        step();
        issue(1, 2, 2, 1, 1, 7, 1, 0, 0);
        step();
        issue(1, 7, 7, 1, 1, 9, 1, 0, 0);
        step();
        check("prio_a", 32'(fwd_a_sel_o), 2);
        check("prio_b", 32'(fwd_b_sel_o), 2);

        // lw r0 then read r0 twice: no stall, no forward
        issue(1, 1, 0, 1, 0, 0, 1, 1, 0);
        step();
        issue(1, 0, 0, 1, 1, 11, 1, 0, 0);
        check("r0_stall", 32'(stall_o), 0);
        step();
        check("r0_a", 32'(fwd_a_sel_o), 0);
        check("r0_b", 32'(fwd_b_sel_o), 0);

        // taken branch, no hazard
        issue(1, 1, 2, 1, 1, 0, 0, 0, 1);
        check("br_flush", 32'(flush_o), 1);
        check("br_stall", 32'(stall_o), 0);
        check("br_pcw", 32'(pc_write_o), 1);
        step();
        check("br_fcnt", 32'(flush_cnt_o), 1);

        // lw r5 ; branch on r5: stall beats flush, branch retried next cycle
        issue(1, 1, 0, 1, 0, 5, 1, 1, 0);
        step();
        issue(1, 5, 6, 1, 1, 0, 0, 0, 1);
        check("brlu_flush", 32'(flush_o), 0);
        check("brlu_stall", 32'(stall_o), 1);
        step();
        check("brlu_scnt", 32'(stall_cnt_o), 2);
        check("brlu_fcnt", 32'(flush_cnt_o), 1);
        check("brlu_reflush", 32'(flush_o), 1);
        step();
        check("brlu_fcnt2", 32'(flush_cnt_o), 2);

        // hold for 3 cycles with a pending load-use and branch
        issue(1, 1, 2, 1, 1, 8, 1, 0, 0);
        step();
        issue(1, 8, 0, 1, 0, 9, 1, 1, 0);
        step();
        check("hold_pre_a", 32'(fwd_a_sel_o), 2);
        hold_i = 1'b1;
        issue(1, 9, 9, 1, 1, 12, 1, 0, 1);
        check("hold_stall", 32'(stall_o), 0);
        check("hold_flush", 32'(flush_o), 0);
        check("hold_pcw", 32'(pc_write_o), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_a", 32'(fwd_a_sel_o), 2);
            check("hold_b", 32'(fwd_b_sel_o), 0);
            check("hold_scnt", 32'(stall_cnt_o), 2);
            check("hold_fcnt", 32'(flush_cnt_o), 2);
        end
        hold_i = 1'b0;
        #1;
        check("unhold_stall", 32'(stall_o), 1);
        check("unhold_flush", 32'(flush_o), 0);

        // reset in the middle of the load-use
        rst_i = 1'b0;
        #1;
        check("mrst_stall", 32'(stall_o), 0);
        check("mrst_pcw", 32'(pc_write_o), 1);
        check("mrst_flush", 32'(flush_o), 0);
        step();
        check("mrst_a", 32'(fwd_a_sel_o), 0);
        check("mrst_b", 32'(fwd_b_sel_o), 0);
        check("mrst_scnt", 32'(stall_cnt_o), 0);
        check("mrst_fcnt", 32'(flush_cnt_o), 0);
        rst_i = 1'b1;
        #1;
        check("post_stall", 32'(stall_o), 0);
        check("post_flush", 32'(flush_o), 1);
        step();
        check("post_fcnt", 32'(flush_cnt_o), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
